// File: rtl/ipf_src_if.sv
// Bundles the pixel fetch, parameter fetch and filter-side stream of the LCU pixel source.
// Widths follow IMG_W: address is log2(IMG_W)*2 bits and the LCU grid index is sized for 16x16 LCUs.
interface ipf_src_if #(
    parameter int IMG_W = 128
);
    localparam int XW = $clog2(IMG_W);
    localparam int AW = 2 * XW;
    localparam int LW = XW - 4;
    localparam int PW = 2 * LW;

    logic          img_rd;
    logic [AW-1:0] img_addr;
    logic [7:0]    img_data;
    logic          prm_rd;
    logic [PW-1:0] prm_addr;
    logic [23:0]   prm_data;
    logic          busy;
    logic          in_en;
    logic [7:0]    din;
    logic [1:0]    ipf_type;
    logic [4:0]    ipf_band_pos;
    logic          ipf_wo_class;
    logic [15:0]   ipf_offset;
    logic [LW-1:0] lcu_x;
    logic [LW-1:0] lcu_y;
    logic [1:0]    lcu_size;

    modport master (
        output img_rd, img_addr, prm_rd, prm_addr,
        input  img_data, prm_data, busy,
        output in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
        output lcu_x, lcu_y, lcu_size
    );

    modport slave (
        input  img_rd, img_addr, prm_rd, prm_addr,
        output img_data, prm_data, busy,
        input  in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
        input  lcu_x, lcu_y, lcu_size
    );
endinterface

// File: rtl/ipf_src.sv
// LCU-ordered pixel source: per LCU fetch params, then stream N*N pixels; first pixel 2 cycles after STREAM entry.
// busy at an edge blanks the next cycle; one in-flight read is parked in a skid register and reads stop while it is full.
module ipf_src #(
    parameter int IMG_W = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  cfg_lcu_size,
    output logic        done,
    ipf_src_if.master   bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int LW = XW - 4;
    localparam int PW = 2 * LW;
    localparam int CW = 6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PARAM  = 3'd1,
        S_PWAIT  = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    lcu_size_q, lcu_size_d;
    logic [LW-1:0] cnt_x_q, cnt_x_d;
    logic [LW-1:0] cnt_y_q, cnt_y_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          rd_done_q, rd_done_d;
    logic          rd_pend_q, rd_pend_d;
    logic          skid_vld_q, skid_vld_d;
    logic [7:0]    skid_dat_q, skid_dat_d;
    logic          in_en_q, in_en_d;
    logic [7:0]    din_q, din_d;
    logic [1:0]    ipf_type_q, ipf_type_d;
    logic [4:0]    ipf_band_q, ipf_band_d;
    logic          ipf_wo_q, ipf_wo_d;
    logic [15:0]   ipf_offset_q, ipf_offset_d;
    logic [LW-1:0] lcu_x_q, lcu_x_d;
    logic [LW-1:0] lcu_y_q, lcu_y_d;

    logic [CW-1:0] nmask;
    logic [LW-1:0] gmax;
    logic [XW-1:0] y_pix;
    logic [XW-1:0] x_pix;
    logic [PW-1:0] lcu_idx;
    logic          img_rd_c;
    logic          frame_go;
    logic          lcu_end;
    logic          lcu_last;

    always_comb begin
        case (lcu_size_q)
            2'd0:    nmask = CW'(15);
            2'd1:    nmask = CW'(31);
            default: nmask = CW'(63);
        endcase
    end

    assign gmax     = {LW{1'b1}} >> lcu_size_q;
    assign y_pix    = (XW'(cnt_y_q) << (4 + int'(lcu_size_q))) + XW'(row_q);
    assign x_pix    = (XW'(cnt_x_q) << (4 + int'(lcu_size_q))) + XW'(col_q);
    assign lcu_idx  = (PW'(cnt_y_q) << (LW - int'(lcu_size_q))) + PW'(cnt_x_q);
    assign frame_go = start && (state_q == S_IDLE || state_q == S_DONE);
    assign lcu_last = (cnt_x_q == gmax) && (cnt_y_q == gmax);
    // All reads issued, none returning, skid empty: the pixel on the output now is the LCU's last one.
    assign lcu_end  = (state_q == S_STREAM) && in_en_q && rd_done_q && !rd_pend_q && !skid_vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_PARAM;
            S_PARAM:  state_d = S_PWAIT;
            S_PWAIT:  state_d = S_STREAM;
            S_STREAM: if (lcu_end) state_d = lcu_last ? S_DONE : S_PARAM;
            S_DONE:   if (start) state_d = S_PARAM;
            default:  state_d = S_IDLE;
        endcase
    end

    // A read is held back while the skid is full, or when a returning read may need the skid this cycle.
    always_comb begin
        img_rd_c     = (state_q == S_STREAM) && !rd_done_q && !skid_vld_q && !(rd_pend_q && bus.busy);
        bus.img_rd   = img_rd_c;
        bus.img_addr = img_rd_c ? {y_pix, x_pix} : '0;
        bus.prm_rd   = (state_q == S_PARAM);
        bus.prm_addr = (state_q == S_PARAM) ? lcu_idx : '0;
        done         = (state_q == S_DONE);
    end

    always_comb begin
        lcu_size_d   = lcu_size_q;
        cnt_x_d      = cnt_x_q;
        cnt_y_d      = cnt_y_q;
        row_d        = row_q;
        col_d        = col_q;
        rd_done_d    = rd_done_q;
        rd_pend_d    = img_rd_c;
        skid_vld_d   = skid_vld_q;
        skid_dat_d   = skid_dat_q;
        in_en_d      = 1'b0;
        din_d        = din_q;
        ipf_type_d   = ipf_type_q;
        ipf_band_d   = ipf_band_q;
        ipf_wo_d     = ipf_wo_q;
        ipf_offset_d = ipf_offset_q;
        lcu_x_d      = lcu_x_q;
        lcu_y_d      = lcu_y_q;

        if (frame_go) begin
            lcu_size_d = (cfg_lcu_size == 2'd3) ? 2'd2 : cfg_lcu_size;
            cnt_x_d    = '0;
            cnt_y_d    = '0;
        end

        if (state_q == S_PARAM) begin
            row_d     = '0;
            col_d     = '0;
            rd_done_d = 1'b0;
        end

        if (state_q == S_PWAIT) begin
            ipf_type_d   = bus.prm_data[23:22];
            ipf_band_d   = bus.prm_data[21:17];
            ipf_wo_d     = bus.prm_data[16];
            ipf_offset_d = bus.prm_data[15:0];
            lcu_x_d      = cnt_x_q;
            lcu_y_d      = cnt_y_q;
        end

        if (img_rd_c) begin
            if (col_q == nmask) begin
                col_d = '0;
                if (row_q == nmask) begin
                    rd_done_d = 1'b1;
                end else begin
                    row_d = row_q + CW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        if (bus.busy) begin
            if (rd_pend_q) begin
                skid_vld_d = 1'b1;
                skid_dat_d = bus.img_data;
            end
        end else if (skid_vld_q) begin
            in_en_d    = 1'b1;
            din_d      = skid_dat_q;
            skid_vld_d = 1'b0;
        end else if (rd_pend_q) begin
            in_en_d = 1'b1;
            din_d   = bus.img_data;
        end

        if (lcu_end && !lcu_last) begin
            if (cnt_x_q == gmax) begin
                cnt_x_d = '0;
                cnt_y_d = cnt_y_q + LW'(1);
            end else begin
                cnt_x_d = cnt_x_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lcu_size_q   <= '0;
            cnt_x_q      <= '0;
            cnt_y_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            rd_done_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            skid_vld_q   <= 1'b0;
            skid_dat_q   <= '0;
            in_en_q      <= 1'b0;
            din_q        <= '0;
            ipf_type_q   <= '0;
            ipf_band_q   <= '0;
            ipf_wo_q     <= 1'b0;
            ipf_offset_q <= '0;
            lcu_x_q      <= '0;
            lcu_y_q      <= '0;
        end else begin
            lcu_size_q   <= lcu_size_d;
            cnt_x_q      <= cnt_x_d;
            cnt_y_q      <= cnt_y_d;
            row_q        <= row_d;
            col_q        <= col_d;
            rd_done_q    <= rd_done_d;
            rd_pend_q    <= rd_pend_d;
            skid_vld_q   <= skid_vld_d;
            skid_dat_q   <= skid_dat_d;
            in_en_q      <= in_en_d;
            din_q        <= din_d;
            ipf_type_q   <= ipf_type_d;
            ipf_band_q   <= ipf_band_d;
            ipf_wo_q     <= ipf_wo_d;
            ipf_offset_q <= ipf_offset_d;
            lcu_x_q      <= lcu_x_d;
            lcu_y_q      <= lcu_y_d;
        end
    end

    assign bus.in_en        = in_en_q;
    assign bus.din          = din_q;
    assign bus.ipf_type     = ipf_type_q;
    assign bus.ipf_band_pos = ipf_band_q;
    assign bus.ipf_wo_class = ipf_wo_q;
    assign bus.ipf_offset   = ipf_offset_q;
    assign bus.lcu_x        = lcu_x_q;
    assign bus.lcu_y        = lcu_y_q;
    assign bus.lcu_size     = lcu_size_q;
endmodule

// File: tb/tb_ipf_src.sv
// Directed bench for ipf_src: memory/parameter responders plus address, parameter and pixel scoreboards.
module tb_ipf_src;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] cfg;
    logic       done;

    ipf_src_if #(.IMG_W(128)) bus();

    ipf_src #(.IMG_W(128)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_lcu_size (cfg),
        .done         (done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] addr;
        logic [2:0]  lx;
        logic [2:0]  ly;
        logic [5:0]  idx;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        exp_pix_q[$];
    logic [13:0] exp_addr_q[$];
    logic [5:0]  exp_prm_q[$];
    logic        pend_img, pend_prm, busy_prev, mon;
    logic [13:0] pend_addr;
    logic [5:0]  pend_paddr;
    int          cyc, pix_cnt, first_en, ncyc;

    function automatic logic [7:0] h(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]};
    endfunction

    function automatic logic [23:0] pdat(input logic [5:0] idx);
        return {idx[1:0], idx[4:0] ^ 5'h15, ~idx[0], 10'h000, idx};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {bus.img_rd, bus.img_addr, bus.prm_rd, bus.prm_addr, bus.in_en, bus.din,
                bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset,
                bus.lcu_x, bus.lcu_y, bus.lcu_size, done};
    endfunction

    task automatic push_frame(input int sz);
        int n, g;
        exp_t e;
        n = 16 << sz;
        g = 128 / n;
        exp_pix_q.delete();
        exp_addr_q.delete();
        exp_prm_q.delete();
        for (int ly = 0; ly < g; ly++) begin
            for (int lx = 0; lx < g; lx++) begin
                exp_prm_q.push_back(6'(ly * g + lx));
                for (int r = 0; r < n; r++) begin
                    for (int c = 0; c < n; c++) begin
                        e.addr = 14'((ly * n + r) * 128 + lx * n + c);
                        e.lx   = 3'(lx);
                        e.ly   = 3'(ly);
                        e.idx  = 6'(ly * g + lx);
                        exp_pix_q.push_back(e);
                        exp_addr_q.push_back(e.addr);
                    end
                end
            end
        end
    endtask

    // Memories answer one cycle after the strobe seen in the previous cycle.
    task automatic drive();
        @(posedge clk);
        #1;
        bus.img_data = pend_img ? h(pend_addr) : 8'($urandom);
        bus.prm_data = pend_prm ? pdat(pend_paddr) : 24'($urandom);
    endtask

    task automatic observe();
        exp_t e;
        @(negedge clk);
        cyc++;
        pend_img   = bus.img_rd;
        pend_addr  = bus.img_addr;
        pend_prm   = bus.prm_rd;
        pend_paddr = bus.prm_addr;
        if (mon) begin
            if (bus.img_rd === 1'b1) begin
                if (exp_addr_q.size() == 0) chk("img_rd_extra", 64'(bus.img_rd), 64'd0);
                else chk("img_addr", 64'(bus.img_addr), 64'(exp_addr_q.pop_front()));
            end
            if (bus.prm_rd === 1'b1) begin
                if (exp_prm_q.size() == 0) chk("prm_rd_extra", 64'(bus.prm_rd), 64'd0);
                else chk("prm_addr", 64'(bus.prm_addr), 64'(exp_prm_q.pop_front()));
            end
            if (busy_prev) chk("in_en_after_busy", 64'(bus.in_en), 64'd0);
            if (bus.in_en === 1'b1) begin
                if (exp_pix_q.size() == 0) chk("in_en_extra", 64'(bus.in_en), 64'd0);
                else begin
                    e = exp_pix_q.pop_front();
                    chk("pixel", 64'({bus.din, bus.lcu_x, bus.lcu_y, bus.ipf_type, bus.ipf_band_pos,
                                      bus.ipf_wo_class, bus.ipf_offset}),
                        64'({h(e.addr), e.lx, e.ly, pdat(e.idx)}));
                end
                if (first_en < 0) first_en = cyc;
                pix_cnt++;
            end
        end
        busy_prev = bus.busy;
    endtask

    task automatic run_frame(input int sz_eff, input int budget, input int busy_pct,
                             input int hold_at, input int poke_at, output int cycles);
        int hold_left;
        bit hold_done, poked, in_hold;
        hold_left = 0;
        hold_done = 0;
        poked     = 0;
        cyc       = 0;
        pix_cnt   = 0;
        first_en  = -1;
        push_frame(sz_eff);
        do begin
            drive();
            if (poke_at >= 0 && !poked && pix_cnt >= poke_at) begin
                start = 1'b1;
                cfg   = 2'd0;
                poked = 1;
            end else begin
                start = 1'b0;
            end
            in_hold = (hold_left > 0);
            if (in_hold) begin
                bus.busy = 1'b1;
                hold_left--;
            end else begin
                bus.busy = (busy_pct > 0) && ($urandom_range(99) < 32'(busy_pct));
            end
            observe();
            if (in_hold) chk("img_rd_in_stall", 64'(bus.img_rd), 64'd0);
            if (!hold_done && hold_at >= 0 && pix_cnt >= hold_at && bus.img_rd === 1'b1) begin
                hold_left = 20;
                hold_done = 1;
            end
        end while (done !== 1'b1 && cyc < budget);
        bus.busy = 1'b0;
        cycles = cyc;
        chk("done", 64'(done), 64'd1);
        chk("pixel_count", 64'(pix_cnt), 64'd16384);
        chk("addr_q_left", 64'(exp_addr_q.size()), 64'd0);
        chk("pix_q_left", 64'(exp_pix_q.size()), 64'd0);
        chk("prm_q_left", 64'(exp_prm_q.size()), 64'd0);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        cfg          = 2'd0;
        bus.busy     = 1'b0;
        bus.img_data = 8'd0;
        bus.prm_data = 24'd0;
        pend_img     = 1'b0;
        pend_prm     = 1'b0;
        pend_addr    = '0;
        pend_paddr   = '0;
        busy_prev    = 1'b0;
        mon          = 1'b1;
        cyc          = 0;

        repeat (3) drive();
        reset = 1'b0;
        observe();
        chk("reset_outputs", all_outs(), 64'd0);

        // Frame 1: 16x16 LCUs, no backpressure, exact cycle count.
        cfg   = 2'd0;
        start = 1'b1;
        run_frame(0, 20000, 0, -1, -1, ncyc);
        chk("f1_cycles", 64'(ncyc), 64'd16641);
        chk("f1_first_in_en", 64'(first_en), 64'd5);
        chk("f1_lcu_size", 64'(bus.lcu_size), 64'd0);

        // Frame 2: restart from DONE, 32x32 LCUs, random busy plus one 20-cycle stall.
        cfg   = 2'd1;
        start = 1'b1;
        run_frame(1, 60000, 30, 100, -1, ncyc);
        chk("f2_lcu_size", 64'(bus.lcu_size), 64'd1);

        // Frame 3: 64x64 LCUs aborted by reset at pixel 500.
        cfg      = 2'd2;
        start    = 1'b1;
        cyc      = 0;
        pix_cnt  = 0;
        first_en = -1;
        push_frame(2);
        drive();
        start = 1'b0;
        observe();
        while (pix_cnt < 500 && cyc < 2000) begin
            drive();
            observe();
        end
        chk("f3_reached_500", 64'(pix_cnt), 64'd500);
        reset = 1'b1;
        drive();
        reset = 1'b0;
        mon   = 1'b0;
        observe();
        chk("f3_reset_outputs", all_outs(), 64'd0);
        exp_pix_q.delete();
        exp_addr_q.delete();
        exp_prm_q.delete();
        mon = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive();
            observe();
            chk("f3_no_in_en", 64'({bus.in_en, bus.img_rd, bus.prm_rd}), 64'd0);
        end

        // Frame 4: cfg 3 behaves as 64x64; a start pulse mid-stream is ignored.
        cfg   = 2'd3;
        start = 1'b1;
        run_frame(2, 20000, 0, -1, 1000, ncyc);
        chk("f4_cycles", 64'(ncyc), 64'd16401);
        chk("f4_lcu_size", 64'(bus.lcu_size), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ipf_src.md
IPF_SRC -- requirements
Module: ipf_src

Interface
REQ-001 SHALL have parameter IMG_W, default 128, image width and height in pixels (square frame, power of two).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: start  in  1  one-cycle frame request; cfg_lcu_size  in  2  0=16x16, 1=32x32, 2=64x64, 3 treated as 2.
REQ-004 SHALL have ports: img_rd  out  1  image memory read strobe; img_addr  out  14  pixel address y*IMG_W+x; img_data  in  8  read data, valid one cycle after img_rd.
REQ-005 SHALL have ports: prm_rd  out  1  parameter read strobe; prm_addr  out  6  LCU index lcu_y*(IMG_W/N)+lcu_x; prm_data  in  24  {type[23:22], band_pos[21:17], wo_class[16], offset[15:0]}, valid one cycle after prm_rd.
REQ-006 SHALL have ports: busy  in  1  filter backpressure; in_en  out  1  din valid; din  out  8  pixel.
REQ-007 SHALL have ports: ipf_type  out  2; ipf_band_pos  out  5; ipf_wo_class  out  1; ipf_offset  out  16; lcu_x  out  3; lcu_y  out  3; lcu_size  out  2; done  out  1  frame fully sent.

Function
REQ-008 SHALL define N = 16<<lcu_size and grid G = IMG_W/N (8, 4, 2 for IMG_W=128).
REQ-009 SHALL implement states IDLE, PARAM, PWAIT, STREAM, DONE.
REQ-010 IDLE: start=1 -> latch cfg_lcu_size into lcu_size, clear LCU counters, go PARAM; start in any other state SHALL be ignored.
REQ-011 PARAM: one-cycle prm_rd=1 with prm_addr of current LCU, go PWAIT.
REQ-012 PWAIT: register prm_data into ipf_type/band_pos/wo_class/offset, drive lcu_x/lcu_y of current LCU, go STREAM.
REQ-013 ipf_* and lcu_x/lcu_y SHALL stay stable from PWAIT exit until the next PWAIT; lcu_size stable from start to next start.
REQ-014 STREAM: pixels SHALL be sent in raster order within the LCU, row 0..N-1, col 0..N-1; img_addr = (lcu_y*N+row)*IMG_W + lcu_x*N + col.
REQ-015 in_en and din SHALL be registered outputs; in_en=1 presents exactly one pixel, consumed in that cycle.
REQ-016 busy sampled at a rising edge equal to 1 SHALL force in_en=0 in the following cycle; the pixel presented in the cycle busy rises counts as consumed.
REQ-017 With busy=0 continuously, in_en SHALL be high every cycle after a 1-cycle read latency: first in_en two cycles after STREAM entry.
REQ-018 One pending read returning during a stall SHALL be held in a 1-entry skid register; no pixel lost, duplicated or reordered; img_rd SHALL not issue while skid is full.
REQ-019 After the last pixel (row=col=N-1) of an LCU is consumed: if lcu_x=G-1 and lcu_y=G-1 go DONE, else advance lcu_x (wrap to 0, increment lcu_y) and go PARAM.
REQ-020 LCU order SHALL be raster: lcu_x fastest.
REQ-021 No in_en during PARAM, PWAIT, DONE, IDLE.
REQ-022 DONE: done=1 held; start=1 in DONE SHALL restart as from IDLE (done clears on that edge).
REQ-023 Address arithmetic SHALL be unsigned, 14-bit, no overflow for IMG_W=128; counters row/col 6 bits, wrap at N-1.
REQ-024 Total in_en pulses per frame SHALL equal IMG_W*IMG_W (16384).

Reset
REQ-025 reset=1 at a rising edge SHALL, in any state, return to IDLE and clear all outputs to 0 (in_en, din, img_rd, img_addr, prm_rd, prm_addr, ipf_*, lcu_*, done) and empty the skid register.
REQ-026 Reset mid-frame SHALL abort without further in_en; a read returning after reset SHALL be discarded.

Verification
REQ-027 Size 0, busy=0, img_data=addr[7:0]: 64 LCUs, first pixels of LCU(1,0) addr 16, LCU(0,1) addr 2048; 16384 in_en; done=1 after last.
REQ-028 Size 2, prm_data per LCU = index: ipf_offset 0,1,2,3 for LCUs (0,0),(1,0),(0,1),(1,1); stable through each LCU; 4096 pixels each.
REQ-029 Size 1, busy toggled random 30%: captured din sequence identical to no-busy run; no in_en cycle following a busy=1 edge.
REQ-030 busy held 1 for 20 cycles mid-row with read in flight: skid holds pixel; stream resumes with that pixel, no gap in addresses.
REQ-031 reset asserted at pixel 500 of frame: next cycle all outputs 0, state IDLE; new start runs full frame from addr 0.
REQ-032 start pulsed during STREAM: ignored, sequence unchanged; cfg_lcu_size=3: behaves as size 2.
